// File: rtl/rr_pkg.sv
// Shared defaults and bundle types for the register-read/issue stage.
// Build with RR_BYPASS_EN defined to enable WB-to-read forwarding.
package rr_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int NREG_DEF     = 8;
    localparam int CTRL_W_DEF   = 7;
    localparam int SRC2_SEL_BIT = 6;

    // Output bundle at the default widths
    typedef struct packed {
        logic [CTRL_W_DEF-1:0]       ctrl;
        logic [XLEN_DEF-1:0]         src1;
        logic [XLEN_DEF-1:0]         src2;
        logic [$clog2(NREG_DEF)-1:0] dst_idx;
        logic                        dst_we;
    } rr_out_t;

endpackage

// File: rtl/reg_read_issue_stage_if.sv
// Decode-in, WB-write and execute-out signals of the register-read stage.
// master = surrounding pipeline, slave = the stage itself.
interface reg_read_issue_stage_if
    import rr_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int IDX_W  = $clog2(NREG),
    parameter int CTRL_W = CTRL_W_DEF
);

    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   imm;
    logic [IDX_W-1:0]  src1_idx;
    logic [IDX_W-1:0]  src2_idx;
    logic [IDX_W-1:0]  dst_idx;
    logic              dst_we;
    logic              wb_we;
    logic [IDX_W-1:0]  wb_idx;
    logic [XLEN-1:0]   wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [XLEN-1:0]   out_src1;
    logic [XLEN-1:0]   out_src2;
    logic [IDX_W-1:0]  out_dst_idx;
    logic              out_dst_we;

    modport master (
        output in_valid, ctrl, imm, src1_idx, src2_idx,
        output dst_idx, dst_we, wb_we, wb_idx, wb_data,
        output flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_src1,
        input  out_src2, out_dst_idx, out_dst_we
    );

    modport slave (
        input  in_valid, ctrl, imm, src1_idx, src2_idx,
        input  dst_idx, dst_we, wb_we, wb_idx, wb_data,
        input  flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_src1,
        output out_src2, out_dst_idx, out_dst_we
    );

endinterface

// File: rtl/rr_scoreboard.sv
// Busy-bit scoreboard for outstanding destination writes.
// RR_BYPASS_EN lets a same-cycle WB clear make a source ready.
module rr_scoreboard
    import rr_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int IDX_W = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic             fclr_en,
    input  logic [IDX_W-1:0] fclr_idx,
    input  logic [IDX_W-1:0] rd1_idx,
    input  logic [IDX_W-1:0] rd2_idx,
    output logic             rd1_rdy,
    output logic             rd2_rdy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // A set in the same cycle as a clear of that index wins
    always_comb begin
        busy_d = busy_q;
        if (clr_en)  busy_d[clr_idx]  = 1'b0;
        if (fclr_en) busy_d[fclr_idx] = 1'b0;
        if (set_en)  busy_d[set_idx]  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

`ifdef RR_BYPASS_EN
    assign rd1_rdy = !busy_q[rd1_idx] || (clr_en && clr_idx == rd1_idx);
    assign rd2_rdy = !busy_q[rd2_idx] || (clr_en && clr_idx == rd2_idx);
`else
    assign rd1_rdy = !busy_q[rd1_idx];
    assign rd2_rdy = !busy_q[rd2_idx];
`endif

endmodule

// File: rtl/reg_read_issue_stage.sv
// Register read + issue: NREG x XLEN regfile, RAW stall, registered output.
// Define RR_BYPASS_EN for WB-to-read forwarding.
module reg_read_issue_stage
    import rr_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int NREG         = NREG_DEF,
    parameter int IDX_W        = $clog2(NREG),
    parameter int CTRL_W       = CTRL_W_DEF,
    parameter int SRC2_SEL_BIT = rr_pkg::SRC2_SEL_BIT
) (
    input logic clk,
    input logic rst,
    reg_read_issue_stage_if.slave io
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   src1;
        logic [XLEN-1:0]   src2;
        logic [IDX_W-1:0]  dst_idx;
        logic              dst_we;
    } out_t;

    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] rf_d [NREG];

    out_t out_q;
    out_t out_d;
    logic out_valid_q;
    logic out_valid_d;

    logic [XLEN-1:0] src1_val;
    logic [XLEN-1:0] src2_val;
    logic [XLEN-1:0] src2_op;
    logic            src2_imm;
    logic            rd1_rdy;
    logic            rd2_rdy;
    logic            hazard;
    logic            in_ready;
    logic            accept;

    always_comb begin
        rf_d = rf_q;
        if (io.wb_we) rf_d[io.wb_idx] = io.wb_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) rf_q <= '{default: '0};
        else      rf_q <= rf_d;
    end

`ifdef RR_BYPASS_EN
    assign src1_val = (io.wb_we && io.wb_idx == io.src1_idx)
                    ? io.wb_data : rf_q[io.src1_idx];
    assign src2_val = (io.wb_we && io.wb_idx == io.src2_idx)
                    ? io.wb_data : rf_q[io.src2_idx];
`else
    assign src1_val = rf_q[io.src1_idx];
    assign src2_val = rf_q[io.src2_idx];
`endif

    assign src2_imm = io.ctrl[SRC2_SEL_BIT];
    assign src2_op  = src2_imm ? io.imm : src2_val;

    rr_scoreboard #(
        .NREG  (NREG),
        .IDX_W (IDX_W)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (accept && io.dst_we),
        .set_idx  (io.dst_idx),
        .clr_en   (io.wb_we),
        .clr_idx  (io.wb_idx),
        .fclr_en  (io.flush && out_valid_q && out_q.dst_we),
        .fclr_idx (out_q.dst_idx),
        .rd1_idx  (io.src1_idx),
        .rd2_idx  (io.src2_idx),
        .rd1_rdy  (rd1_rdy),
        .rd2_rdy  (rd2_rdy)
    );

    // src2 readiness is irrelevant when the immediate is selected
    assign hazard   = !rd1_rdy || (!src2_imm && !rd2_rdy);
    assign in_ready = rst && !io.flush && !hazard
                   && (!out_valid_q || io.out_ready);
    assign accept   = io.in_valid && in_ready;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_d.ctrl    = io.ctrl;
            out_d.src1    = src1_val;
            out_d.src2    = src2_op;
            out_d.dst_idx = io.dst_idx;
            out_d.dst_we  = io.dst_we;
            out_valid_d   = 1'b1;
        end else if (io.flush || io.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign io.in_ready    = in_ready;
    assign io.out_valid   = out_valid_q;
    assign io.out_ctrl    = out_q.ctrl;
    assign io.out_src1    = out_q.src1;
    assign io.out_src2    = out_q.src2;
    assign io.out_dst_idx = out_q.dst_idx;
    assign io.out_dst_we  = out_q.dst_we;

endmodule

// File: tb/tb_reg_read_issue_stage.sv
// Directed bench for reg_read_issue_stage (default or RR_BYPASS_EN build).
module tb_reg_read_issue_stage;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    reg_read_issue_stage_if io ();

    reg_read_issue_stage dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] c, input logic [31:0] im,
                         input logic [2:0] s1, input logic [2:0] s2,
                         input logic we, input logic [2:0] d);
        io.ctrl     = c;
        io.imm      = im;
        io.src1_idx = s1;
        io.src2_idx = s2;
        io.dst_we   = we;
        io.dst_idx  = d;
        io.in_valid = 1'b1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b0;
        io.in_valid = 1'b0;
        io.ctrl     = '0;
        io.imm      = '0;
        io.src1_idx = '0;
        io.src2_idx = '0;
        io.dst_idx  = '0;
        io.dst_we   = 1'b0;
        io.wb_we    = 1'b0;
        io.wb_idx   = '0;
        io.wb_data  = '0;
        io.flush    = 1'b0;
        io.out_ready = 1'b1;

        tick();
        tick();
        check("rst_valid", io.out_valid, 0);
        check("rst_ctrl", io.out_ctrl, 0);
        check("rst_src1", io.out_src1, 0);
        check("rst_src2", io.out_src2, 0);
        check("rst_dst", io.out_dst_idx, 0);
        check("rst_dwe", io.out_dst_we, 0);
        check("rst_rdy", io.in_ready, 0);
        rst = 1'b1;

        // r5 reads zero after reset
        issue(7'h00, 32'h0, 3'd5, 3'd5, 1'b0, 3'd0);
        #1 check("r5_rdy", io.in_ready, 1);
        tick();
        check("r5_valid", io.out_valid, 1);
        check("r5_src1", io.out_src1, 0);
        check("r5_src2", io.out_src2, 0);

        // write r3, then read it with immediate src2
        io.in_valid = 1'b0;
        io.wb_we    = 1'b1;
        io.wb_idx   = 3'd3;
        io.wb_data  = 32'hDEADBEEF;
        tick();
        io.wb_we = 1'b0;
        issue(7'h40, 32'h10, 3'd3, 3'd0, 1'b0, 3'd0);
        #1 check("wr_rdy", io.in_ready, 1);
        tick();
        check("wr_src1", io.out_src1, 32'hDEADBEEF);
        check("wr_src2", io.out_src2, 32'h10);
        check("wr_ctrl", io.out_ctrl, 7'h40);

        // RAW on r2
        issue(7'h01, 32'h0, 3'd0, 3'd0, 1'b1, 3'd2);
        tick();
        check("raw_a_dwe", io.out_dst_we, 1);
        check("raw_a_dst", io.out_dst_idx, 2);
        issue(7'h02, 32'h0, 3'd2, 3'd0, 1'b0, 3'd0);
        #1 check("raw_stall", io.in_ready, 0);
        tick();
        check("raw_drain", io.out_valid, 0);
        io.wb_we   = 1'b1;
        io.wb_idx  = 3'd2;
        io.wb_data = 32'h55;
`ifdef RR_BYPASS_EN
        #1 check("raw_byp_rdy", io.in_ready, 1);
        tick();
        io.wb_we = 1'b0;
`else
        #1 check("raw_wb_rdy", io.in_ready, 0);
        tick();
        io.wb_we = 1'b0;
        #1 check("raw_late_rdy", io.in_ready, 1);
        tick();
`endif
        check("raw_b_ctrl", io.out_ctrl, 7'h02);
        check("raw_b_src1", io.out_src1, 32'h55);

        // backpressure
        issue(7'h43, 32'h77, 3'd3, 3'd0, 1'b0, 3'd0);
        tick();
        io.out_ready = 1'b0;
        issue(7'h04, 32'h0, 3'd2, 3'd3, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_rdy", io.in_ready, 0);
            check("bp_valid", io.out_valid, 1);
            check("bp_ctrl", io.out_ctrl, 7'h43);
            check("bp_src2", io.out_src2, 32'h77);
            tick();
        end
        check("bp_src1", io.out_src1, 32'hDEADBEEF);
        io.out_ready = 1'b1;
        #1 check("bp_rel_rdy", io.in_ready, 1);
        tick();
        check("bp_d_ctrl", io.out_ctrl, 7'h04);
        check("bp_d_src1", io.out_src1, 32'h55);
        check("bp_d_src2", io.out_src2, 32'hDEADBEEF);

        // same-index set and clear on r4
        issue(7'h05, 32'h0, 3'd0, 3'd0, 1'b1, 3'd4);
        tick();
        issue(7'h06, 32'h0, 3'd0, 3'd0, 1'b1, 3'd4);
        io.wb_we   = 1'b1;
        io.wb_idx  = 3'd4;
        io.wb_data = 32'h44;
        #1 check("sc_rdy", io.in_ready, 1);
        tick();
        io.wb_we = 1'b0;
        issue(7'h07, 32'h0, 3'd4, 3'd0, 1'b0, 3'd0);
        #1 check("sc_stall", io.in_ready, 0);
        tick();
        check("sc_stall2", io.in_ready, 0);
        check("sc_ctrl", io.out_ctrl, 7'h06);
        io.in_valid = 1'b0;
        io.wb_we    = 1'b1;
        io.wb_idx   = 3'd4;
        io.wb_data  = 32'h99;
        tick();
        io.wb_we = 1'b0;

        // flush while output holds a dst=6 writer
        io.out_ready = 1'b0;
        issue(7'h08, 32'h0, 3'd0, 3'd0, 1'b1, 3'd6);
        #1 check("fl_h_rdy", io.in_ready, 1);
        tick();
        check("fl_h_valid", io.out_valid, 1);
        check("fl_h_dst", io.out_dst_idx, 6);
        check("fl_h_dwe", io.out_dst_we, 1);
        issue(7'h09, 32'h0, 3'd0, 3'd0, 1'b0, 3'd0);
        io.flush   = 1'b1;
        io.wb_we   = 1'b1;
        io.wb_idx  = 3'd7;
        io.wb_data = 32'h70;
        #1 check("fl_rdy", io.in_ready, 0);
        tick();
        io.flush = 1'b0;
        io.wb_we = 1'b0;
        check("fl_valid", io.out_valid, 0);
        io.out_ready = 1'b1;
        issue(7'h0A, 32'h0, 3'd6, 3'd7, 1'b0, 3'd0);
        #1 check("fl_busy6", io.in_ready, 1);
        tick();
        check("fl_j_valid", io.out_valid, 1);
        check("fl_j_ctrl", io.out_ctrl, 7'h0A);
        check("fl_j_src1", io.out_src1, 0);
        check("fl_j_src2", io.out_src2, 32'h70);
        io.in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
